// File: rtl/prog_seq_if.sv
// Bundle of run-control, branch, LUT-write and fetch-address signals between
// the instruction-control logic (master) and the program sequencer (slave).
interface prog_seq_if #(
  parameter int PC_W      = 6,
  parameter int LUT_IDX_W = 3
);
  logic                 Start;
  logic                 Stall;
  logic                 Jen;
  logic                 Jrel;
  logic [LUT_IDX_W-1:0] Jptr;
  logic                 Call;
  logic                 Ret;
  logic                 Halt;
  logic                 LutWe;
  logic [LUT_IDX_W-1:0] LutWaddr;
  logic [PC_W-1:0]      LutWdata;
  logic [PC_W-1:0]      PC;
  logic                 Busy;
  logic                 Done;
  logic                 StackErr;
  logic [1:0]           dbg_state;

  modport master (
    output Start, Stall, Jen, Jrel, Jptr, Call, Ret, Halt, LutWe, LutWaddr, LutWdata,
    input  PC, Busy, Done, StackErr, dbg_state
  );

  modport slave (
    input  Start, Stall, Jen, Jrel, Jptr, Call, Ret, Halt, LutWe, LutWaddr, LutWdata,
    output PC, Busy, Done, StackErr, dbg_state
  );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: registered fetch address with branch LUT, absolute/relative
// branches, call/return stack, stall and an IDLE/RUN/DONE/ERR run-control FSM.
module prog_seq #(
  parameter int PC_W        = 6,
  parameter int LUT_IDX_W   = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  prog_seq_if.slave  bus
);
  localparam int LUT_N = 2 ** LUT_IDX_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, lut_val, target;
  logic [SP_W-1:0] sp, sp_n;
  logic            push;
  logic            stack_full, stack_empty;
  logic [IDX_W-1:0] top_idx, push_idx;

  logic [PC_W-1:0] lut   [LUT_N];
  logic [PC_W-1:0] stack [STACK_DEPTH];

  assign pc_inc      = pc + PC_W'(1);
  // Combinational read sees the pre-write contents when the same index is written this edge.
  assign lut_val     = lut[bus.Jptr];
  assign target      = bus.Jrel ? pc + lut_val : lut_val;
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign push_idx    = IDX_W'(sp);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    sp_n    = sp;
    push    = 1'b0;
    case (state)
      RUN: begin
        if (!bus.Stall) begin
          if (bus.Halt) begin
            state_n = DONE;
          end else if (bus.Ret) begin
            if (stack_empty) begin
              state_n = ERR;
            end else begin
              pc_n = stack[top_idx];
              sp_n = sp - SP_W'(1);
            end
          end else if (bus.Call) begin
            if (stack_full) begin
              state_n = ERR;
            end else begin
              push = 1'b1;
              pc_n = target;
              sp_n = sp + SP_W'(1);
            end
          end else if (bus.Jen) begin
            pc_n = target;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      default: begin
        if (bus.Start) begin
          state_n = RUN;
          pc_n    = '0;
          sp_n    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= '0;
      sp    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      sp    <= sp_n;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  // LUT writes are independent of the run state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (bus.LutWe) begin
      lut[bus.LutWaddr] <= bus.LutWdata;
    end
  end

  assign bus.PC        = pc;
  assign bus.Busy      = (state == RUN);
  assign bus.Done      = (state == DONE);
  assign bus.StackErr  = (state == ERR);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: reference model predicts each edge's outputs into a queue,
// compared after the edge; directed scenarios plus a random phase.
module tb_prog_seq;
  localparam int PC_W      = 6;
  localparam int LUT_IDX_W = 3;
  localparam int DEPTH     = 4;
  localparam int W         = PC_W + 3;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  prog_seq_if #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) bus ();

  prog_seq #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W), .STACK_DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model
  int              m_state;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stack[$];
  logic [PC_W-1:0] m_lut[2**LUT_IDX_W];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.Busy, bus.Done, bus.StackErr, bus.PC};
  endfunction

  task automatic clear_inputs();
    bus.Start = 0; bus.Stall = 0; bus.Jen = 0; bus.Jrel = 0; bus.Jptr = '0;
    bus.Call = 0; bus.Ret = 0; bus.Halt = 0;
    bus.LutWe = 0; bus.LutWaddr = '0; bus.LutWdata = '0;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = '0;
    m_stack.delete();
    foreach (m_lut[i]) m_lut[i] = '0;
  endtask

  task automatic lut_wr(input int idx, input int data);
    bus.LutWe    = 1;
    bus.LutWaddr = LUT_IDX_W'(idx);
    bus.LutWdata = PC_W'(data);
  endtask

  // Predict from the currently driven inputs, clock once, compare, release inputs.
  task automatic tick(input string tag);
    logic [PC_W-1:0] tgt;
    logic [W-1:0]    e;
    tgt = bus.Jrel ? m_pc + m_lut[bus.Jptr] : m_lut[bus.Jptr];
    if (m_state != 1) begin
      if (bus.Start) begin
        m_state = 1;
        m_pc    = '0;
        m_stack.delete();
      end
    end else if (!bus.Stall) begin
      if (bus.Halt) m_state = 2;
      else if (bus.Ret) begin
        if (m_stack.size() == 0) m_state = 3;
        else m_pc = m_stack.pop_back();
      end else if (bus.Call) begin
        if (m_stack.size() == DEPTH) m_state = 3;
        else begin
          m_stack.push_back(m_pc + PC_W'(1));
          m_pc = tgt;
        end
      end else if (bus.Jen) m_pc = tgt;
      else m_pc = m_pc + PC_W'(1);
    end
    if (bus.LutWe) m_lut[bus.LutWaddr] = bus.LutWdata;
    exp_q.push_back({m_state == 1, m_state == 2, m_state == 3, m_pc});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check(tag, obs(), e);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    Reset = 0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out", obs(), 0);
    check("rst_state", bus.dbg_state, 0);
    @(negedge Clk);
    Reset = 1;
    @(posedge Clk);
    #1;
    tick("idle_hold");
    check("idle_pc", bus.PC, 0);

    // 1: start and sequential stepping
    bus.Start = 1; tick("t1_start");
    check("t1_busy", bus.Busy, 1);
    check("t1_pc0", bus.PC, 0);
    tick("t1_seq"); tick("t1_seq"); tick("t1_seq");
    check("t1_pc3", bus.PC, 3);
    bus.Start = 1; tick("t1_start_ignored");

    // 2: absolute branch
    lut_wr(2, 'h14); tick("t2_wr");
    check("t2_pc5", bus.PC, 5);
    bus.Jen = 1; bus.Jptr = 2; tick("t2_jmp");
    check("t2_abs", bus.PC, 'h14);
    tick("t2_seq");
    check("t2_next", bus.PC, 'h15);

    // 3: same-cycle LUT write/read, relative branches, wrap
    lut_wr(3, 'h3C); bus.Jen = 1; bus.Jptr = 3; tick("t3_old_read");
    check("t3_old_val", bus.PC, 0);
    lut_wr(4, 10); tick("t3_wr4");
    bus.Jen = 1; bus.Jptr = 4; tick("t3_to10");
    bus.Jen = 1; bus.Jrel = 1; bus.Jptr = 3; tick("t3_rel");
    check("t3_rel_back", bus.PC, 6);
    lut_wr(5, 2); tick("t3_wr5");
    bus.Jen = 1; bus.Jptr = 5; tick("t3_to2");
    bus.Jen = 1; bus.Jrel = 1; bus.Jptr = 3; tick("t3_rel_wrap");
    check("t3_wrap_low", bus.PC, 62);
    tick("t3_seq");
    tick("t3_seq_wrap");
    check("t3_wrap_top", bus.PC, 0);

    // 4: call/return stack and overflow
    tick("t4_seq");
    bus.Stall = 1; bus.Jen = 1; lut_wr(6, 8); tick("t4_stall_wr");
    check("t4_stall_pc", bus.PC, 1);
    bus.Call = 1; bus.Jptr = 6; tick("t4_call1");
    check("t4_call1_pc", bus.PC, 8);
    bus.Stall = 1; lut_wr(7, 16); tick("t4_stall_wr");
    bus.Call = 1; bus.Jptr = 7; bus.Jen = 1; tick("t4_call2");
    bus.Call = 1; bus.Jptr = 6; bus.Jrel = 1; tick("t4_call3");
    check("t4_call3_pc", bus.PC, 24);
    bus.Call = 1; bus.Jptr = 7; tick("t4_call4");
    bus.Ret = 1; bus.Call = 1; tick("t4_ret1"); check("t4_ret25", bus.PC, 25);
    bus.Ret = 1; tick("t4_ret2"); check("t4_ret17", bus.PC, 17);
    bus.Ret = 1; tick("t4_ret3"); check("t4_ret9", bus.PC, 9);
    bus.Ret = 1; tick("t4_ret4"); check("t4_ret2", bus.PC, 2);
    for (int i = 0; i < DEPTH; i++) begin
      bus.Call = 1; bus.Jptr = 7; tick("t4_fill");
    end
    bus.Call = 1; bus.Jptr = 7; tick("t4_overflow");
    check("t4_err", {bus.StackErr, bus.Busy}, 2'b10);
    check("t4_err_state", bus.dbg_state, 3);
    tick("t4_err_hold"); tick("t4_err_hold");
    check("t4_frozen", bus.PC, 16);

    // 5: halt with stall, done, restart, underflow
    bus.Start = 1; tick("t5_start");
    tick("t5_seq");
    bus.Halt = 1; bus.Stall = 1; tick("t5_halt_stall");
    check("t5_held_busy", bus.Busy, 1);
    bus.Halt = 1; tick("t5_halt");
    check("t5_done", {bus.Done, bus.PC}, {1'b1, 6'd1});
    tick("t5_done_hold");
    bus.Start = 1; tick("t5_restart");
    check("t5_restart_pc", {bus.Busy, bus.PC}, {1'b1, 6'd0});
    bus.Ret = 1; tick("t5_underflow");
    check("t5_underflow_err", bus.StackErr, 1);

    // 6: asynchronous reset mid-run clears LUT and stack
    bus.Start = 1; tick("t6_start");
    lut_wr(1, 9); tick("t6_wr1");
    bus.Call = 1; bus.Jptr = 7; tick("t6_call");
    bus.Call = 1; bus.Jptr = 7; tick("t6_call");
    Reset = 0;
    #1;
    check("t6_rst_out", obs(), 0);
    check("t6_rst_state", bus.dbg_state, 0);
    model_reset();
    Reset = 1;
    bus.Start = 1; tick("t6_restart");
    bus.Jen = 1; bus.Jptr = 1; tick("t6_lut_cleared");
    check("t6_lut1_zero", bus.PC, 0);
    bus.Ret = 1; tick("t6_stack_cleared");

    // random mix
    for (int i = 0; i < 200; i++) begin
      bus.Start = ($urandom_range(0, 3) == 0);
      bus.Stall = ($urandom_range(0, 3) == 0);
      bus.Jen   = 1'($urandom_range(0, 1));
      bus.Jrel  = 1'($urandom_range(0, 1));
      bus.Jptr  = LUT_IDX_W'($urandom_range(0, 7));
      bus.Call  = ($urandom_range(0, 4) == 0);
      bus.Ret   = ($urandom_range(0, 4) == 0);
      bus.Halt  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) lut_wr($urandom_range(0, 7), $urandom_range(0, 63));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
